stopwatch_ctrl: RTL and testbench

Run/stop/clear sequencer for the stopwatch datapath. It consumes single-cycle, already-debounced button pulses and owns the run state. It generates the gated timebase tick that advances the time counter, plus the clear pulse and lap-freeze control that drive the counter and display blocks. It sits between the button debounce instances and the stopwatch counter/FND path.

---
 rtl/stopwatch_ctrl_if.sv | 33 +++
 rtl/stopwatch_ctrl.sv | 134 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_if
// Bundles the stopwatch sequencer's button pulses and its control outputs.
//   i_run_stop : debounced single-cycle pulse, toggles run/stop
//   i_clear    : debounced single-cycle pulse, requests a counter clear
//   i_lap      : debounced single-cycle pulse, lap freeze/release
//   o_run      : 1 while running
//   o_tick     : single-cycle timebase pulse to the time counter
//   o_clear    : single-cycle synchronous clear to the time counter
//   o_lap      : level, 1 = display holds its latched value
//   o_state    : encoded state (00 STOP, 01 RUN, 10 CLEAR)
// master drives the buttons and observes the outputs; slave is the sequencer.
// -----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
    logic       i_run_stop;
    logic       i_clear;
    logic       i_lap;
    logic       o_run;
    logic       o_tick;
    logic       o_clear;
    logic       o_lap;
    logic [1:0] o_state;

    modport master (
        output i_run_stop, i_clear, i_lap,
        input  o_run, o_tick, o_clear, o_lap, o_state
    );

    modport slave (
        input  i_run_stop, i_clear, i_lap,
        output o_run, o_tick, o_clear, o_lap, o_state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Run/stop/clear sequencer for the stopwatch datapath. Owns the run state,
// divides the system clock down to the gated timebase tick, and produces the
// counter clear pulse and the lap-freeze level for the display path.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset (0 = reset)
//   io_sw  : stopwatch_ctrl_if.slave (button pulses in, control outputs out)
// Parameters:
//   CLK_HZ  : system clock frequency in Hz
//   TICK_HZ : tick rate while running; DIV = CLK_HZ/TICK_HZ must be >= 2
// Every output is a flop or a decode of the state flop, so no input reaches
// an output combinationally.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic              clk,
    input  logic              reset,
    stopwatch_ctrl_if.slave   io_sw
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    // Guarded so a bad DIV reports the error below instead of a zero width.
    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_lap;
    logic             w_lap_nxt;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Prescaler, tick and lap registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= CNT_ZERO;
            r_tick <= 1'b0;
            r_lap  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tick <= w_tick_nxt;
            r_lap  <= w_lap_nxt;
        end
    end

    // Next-state, prescaler and lap decisions, all taken from the pre-edge state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tick_nxt  = 1'b0;
        w_lap_nxt   = r_lap;
        case (r_state)
            ST_STOP: begin
                // cnt is held so the sub-tick fraction survives a stop/start.
                if (io_sw.i_clear) begin
                    w_state_nxt = ST_CLEAR;
                end else if (io_sw.i_run_stop) begin
                    w_state_nxt = ST_RUN;
                end else if (io_sw.i_lap && r_lap) begin
                    // Lap can only be released while stopped, never engaged.
                    w_lap_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_RUN: begin
                // Stop and lap act independently; clear is ignored while running.
                if (io_sw.i_run_stop) begin
                    w_state_nxt = ST_STOP;
                end else begin
                    w_state_nxt = ST_RUN;
                end
                if (io_sw.i_lap) begin
                    w_lap_nxt = ~r_lap;
                end else begin
                    w_lap_nxt = r_lap;
                end
                // A tick due on the stopping edge still fires.
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt  = CNT_ZERO;
                    w_tick_nxt = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + CNT_ONE;
                    w_tick_nxt = 1'b0;
                end
            end
            ST_CLEAR: begin
                w_state_nxt = ST_STOP;
                w_cnt_nxt   = CNT_ZERO;
                w_lap_nxt   = 1'b0;
            end
            default: begin
                // Unused encoding 11: recover to STOP.
                w_state_nxt = ST_STOP;
            end
        endcase
    end

    assign io_sw.o_run   = (r_state == ST_RUN);
    assign io_sw.o_clear = (r_state == ST_CLEAR);
    assign io_sw.o_state = r_state;
    assign io_sw.o_tick  = r_tick;
    assign io_sw.o_lap   = r_lap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl with CLK_HZ=1000, TICK_HZ=100 (DIV=10).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(
        .CLK_HZ  (1000),
        .TICK_HZ (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_sw (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic rs, input logic cl, input logic lp);
        sw_if.i_run_stop = rs;
        sw_if.i_clear    = cl;
        sw_if.i_lap      = lp;
        step();
        sw_if.i_run_stop = 1'b0;
        sw_if.i_clear    = 1'b0;
        sw_if.i_lap      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sw_if.i_run_stop = 1'b0;
        sw_if.i_clear    = 1'b0;
        sw_if.i_lap      = 1'b0;
        repeat (3) step();
        n_chk++; if (sw_if.o_run !== 1'b0) begin n_err++; $display("FAIL reset_run: got %b expected 0", sw_if.o_run); end
        n_chk++; if (sw_if.o_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b expected 0", sw_if.o_tick); end
        n_chk++; if (sw_if.o_clear !== 1'b0) begin n_err++; $display("FAIL reset_clear: got %b expected 0", sw_if.o_clear); end
        n_chk++; if (sw_if.o_lap !== 1'b0) begin n_err++; $display("FAIL reset_lap: got %b expected 0", sw_if.o_lap); end
        n_chk++; if (sw_if.o_state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b expected 00", sw_if.o_state); end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) step();
        n_chk++; if (sw_if.o_state !== 2'b00) begin n_err++; $display("FAIL post_reset_state: got %b expected 00", sw_if.o_state); end
        n_chk++; if (sw_if.o_run !== 1'b0) begin n_err++; $display("FAIL post_reset_run: got %b expected 0", sw_if.o_run); end
    endtask

    task automatic test_run_tick();
        pulse(1'b1, 1'b0, 1'b0);
        n_chk++; if (sw_if.o_run !== 1'b1) begin n_err++; $display("FAIL run_enter_run: got %b expected 1", sw_if.o_run); end
        n_chk++; if (sw_if.o_state !== 2'b01) begin n_err++; $display("FAIL run_enter_state: got %b expected 01", sw_if.o_state); end
        n_chk++; if (sw_if.o_tick !== 1'b0) begin n_err++; $display("FAIL run_enter_tick: got %b expected 0", sw_if.o_tick); end
        // Ticks on edges 10, 20, 30 after entry, one cycle wide.
        for (int k = 1; k <= 30; k++) begin
            step();
            n_chk++;
            if (sw_if.o_tick !== ((k % 10) == 0)) begin
                n_err++; $display("FAIL run_tick_k%0d: got %b expected %b", k, sw_if.o_tick, ((k % 10) == 0));
            end
        end
    endtask

    task automatic test_stop_resume();
        // cnt is 0 here; 24 edges plus the stopping edge leave cnt = 5.
        for (int k = 1; k <= 24; k++) begin
            step();
            n_chk++;
            if (sw_if.o_tick !== ((k % 10) == 0)) begin
                n_err++; $display("FAIL sr_tick_k%0d: got %b expected %b", k, sw_if.o_tick, ((k % 10) == 0));
            end
        end
        pulse(1'b1, 1'b0, 1'b0);
        n_chk++; if (sw_if.o_state !== 2'b00) begin n_err++; $display("FAIL sr_stop_state: got %b expected 00", sw_if.o_state); end
        n_chk++; if (sw_if.o_run !== 1'b0) begin n_err++; $display("FAIL sr_stop_run: got %b expected 0", sw_if.o_run); end
        for (int k = 1; k <= 50; k++) begin
            step();
            n_chk++;
            if (sw_if.o_tick !== 1'b0) begin
                n_err++; $display("FAIL sr_idle_tick_k%0d: got %b expected 0", k, sw_if.o_tick);
            end
        end
        pulse(1'b1, 1'b0, 1'b0);
        n_chk++; if (sw_if.o_state !== 2'b01) begin n_err++; $display("FAIL sr_resume_state: got %b expected 01", sw_if.o_state); end
        for (int k = 1; k <= 5; k++) begin
            step();
            n_chk++;
            if (sw_if.o_tick !== (k == 5)) begin
                n_err++; $display("FAIL sr_resume_tick_k%0d: got %b expected %b", k, sw_if.o_tick, (k == 5));
            end
        end
    endtask

    task automatic test_clear();
        pulse(1'b1, 1'b0, 1'b0);
        n_chk++; if (sw_if.o_state !== 2'b00) begin n_err++; $display("FAIL clr_pre_state: got %b expected 00", sw_if.o_state); end
        // Clear beats run_stop; run_stop held through CLEAR is ignored.
        sw_if.i_clear    = 1'b1;
        sw_if.i_run_stop = 1'b1;
        step();
        n_chk++; if (sw_if.o_state !== 2'b10) begin n_err++; $display("FAIL clr_state: got %b expected 10", sw_if.o_state); end
        n_chk++; if (sw_if.o_clear !== 1'b1) begin n_err++; $display("FAIL clr_pulse: got %b expected 1", sw_if.o_clear); end
        n_chk++; if (sw_if.o_run !== 1'b0) begin n_err++; $display("FAIL clr_run: got %b expected 0", sw_if.o_run); end
        sw_if.i_clear = 1'b0;
        step();
        sw_if.i_run_stop = 1'b0;
        n_chk++; if (sw_if.o_state !== 2'b00) begin n_err++; $display("FAIL clr_after_state: got %b expected 00", sw_if.o_state); end
        n_chk++; if (sw_if.o_clear !== 1'b0) begin n_err++; $display("FAIL clr_after_pulse: got %b expected 0", sw_if.o_clear); end
        n_chk++; if (sw_if.o_run !== 1'b0) begin n_err++; $display("FAIL clr_after_run: got %b expected 0", sw_if.o_run); end
        step();
        n_chk++; if (sw_if.o_state !== 2'b00) begin n_err++; $display("FAIL clr_idle_state: got %b expected 00", sw_if.o_state); end
        // cnt was 1 before the clear; a full 10-edge wait proves it is 0.
        pulse(1'b1, 1'b0, 1'b0);
        n_chk++; if (sw_if.o_state !== 2'b01) begin n_err++; $display("FAIL clr_rerun_state: got %b expected 01", sw_if.o_state); end
        for (int k = 1; k <= 10; k++) begin
            step();
            n_chk++;
            if (sw_if.o_tick !== (k == 10)) begin
                n_err++; $display("FAIL clr_cnt_tick_k%0d: got %b expected %b", k, sw_if.o_tick, (k == 10));
            end
        end
    endtask

    task automatic test_lap();
        pulse(1'b0, 1'b0, 1'b1);
        n_chk++; if (sw_if.o_lap !== 1'b1) begin n_err++; $display("FAIL lap_set: got %b expected 1", sw_if.o_lap); end
        for (int k = 1; k <= 9; k++) begin
            step();
            n_chk++;
            if (sw_if.o_tick !== (k == 9) || sw_if.o_lap !== 1'b1) begin
                n_err++; $display("FAIL lap_run_k%0d: got tick=%b lap=%b expected tick=%b lap=1", k, sw_if.o_tick, sw_if.o_lap, (k == 9));
            end
        end
        pulse(1'b1, 1'b0, 1'b0);
        n_chk++; if (sw_if.o_state !== 2'b00 || sw_if.o_lap !== 1'b1) begin n_err++; $display("FAIL lap_stop: got state=%b lap=%b expected state=00 lap=1", sw_if.o_state, sw_if.o_lap); end
        pulse(1'b0, 1'b0, 1'b1);
        n_chk++; if (sw_if.o_lap !== 1'b0) begin n_err++; $display("FAIL lap_release_stop: got %b expected 0", sw_if.o_lap); end
        pulse(1'b0, 1'b0, 1'b1);
        n_chk++; if (sw_if.o_lap !== 1'b0 || sw_if.o_state !== 2'b00) begin n_err++; $display("FAIL lap_noop_stop: got lap=%b state=%b expected lap=0 state=00", sw_if.o_lap, sw_if.o_state); end
        pulse(1'b1, 1'b0, 1'b0);
        // Stop and lap on the same RUN edge: both act.
        pulse(1'b1, 1'b0, 1'b1);
        n_chk++; if (sw_if.o_state !== 2'b00 || sw_if.o_lap !== 1'b1) begin n_err++; $display("FAIL lap_stop_same_edge: got state=%b lap=%b expected state=00 lap=1", sw_if.o_state, sw_if.o_lap); end
        pulse(1'b0, 1'b1, 1'b0);
        n_chk++; if (sw_if.o_state !== 2'b10 || sw_if.o_clear !== 1'b1 || sw_if.o_lap !== 1'b1) begin n_err++; $display("FAIL lap_clear_enter: got state=%b clear=%b lap=%b expected 10/1/1", sw_if.o_state, sw_if.o_clear, sw_if.o_lap); end
        step();
        n_chk++; if (sw_if.o_state !== 2'b00 || sw_if.o_clear !== 1'b0 || sw_if.o_lap !== 1'b0) begin n_err++; $display("FAIL lap_clear_exit: got state=%b clear=%b lap=%b expected 00/0/0", sw_if.o_state, sw_if.o_clear, sw_if.o_lap); end
    endtask

    task automatic test_clear_in_run_stop_at_wrap();
        pulse(1'b1, 1'b0, 1'b0);
        n_chk++; if (sw_if.o_state !== 2'b01) begin n_err++; $display("FAIL wrap_enter_state: got %b expected 01", sw_if.o_state); end
        repeat (4) step();
        pulse(1'b0, 1'b1, 1'b0);
        n_chk++; if (sw_if.o_clear !== 1'b0 || sw_if.o_state !== 2'b01) begin n_err++; $display("FAIL run_clear_ignored: got clear=%b state=%b expected 0/01", sw_if.o_clear, sw_if.o_state); end
        // cnt is 5; four more edges bring it to 9 without a tick.
        for (int k = 1; k <= 4; k++) begin
            step();
            n_chk++;
            if (sw_if.o_tick !== 1'b0) begin
                n_err++; $display("FAIL wrap_pre_tick_k%0d: got %b expected 0", k, sw_if.o_tick);
            end
        end
        pulse(1'b1, 1'b0, 1'b0);
        n_chk++; if (sw_if.o_tick !== 1'b1 || sw_if.o_state !== 2'b00) begin n_err++; $display("FAIL wrap_stop_tick: got tick=%b state=%b expected 1/00", sw_if.o_tick, sw_if.o_state); end
        for (int k = 1; k <= 20; k++) begin
            step();
            n_chk++;
            if (sw_if.o_tick !== 1'b0) begin
                n_err++; $display("FAIL wrap_idle_tick_k%0d: got %b expected 0", k, sw_if.o_tick);
            end
        end
        pulse(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            n_chk++;
            if (sw_if.o_tick !== (k == 10)) begin
                n_err++; $display("FAIL wrap_cnt_tick_k%0d: got %b expected %b", k, sw_if.o_tick, (k == 10));
            end
        end
    endtask

    task automatic test_async_reset();
        pulse(1'b0, 1'b0, 1'b1);
        repeat (8) step();
        step();
        n_chk++; if (sw_if.o_tick !== 1'b1 || sw_if.o_lap !== 1'b1 || sw_if.o_run !== 1'b1) begin n_err++; $display("FAIL ar_pre: got tick=%b lap=%b run=%b expected 1/1/1", sw_if.o_tick, sw_if.o_lap, sw_if.o_run); end
        #2;
        reset = 1'b0;
        #1;
        n_chk++; if (sw_if.o_run !== 1'b0) begin n_err++; $display("FAIL ar_run: got %b expected 0", sw_if.o_run); end
        n_chk++; if (sw_if.o_lap !== 1'b0) begin n_err++; $display("FAIL ar_lap: got %b expected 0", sw_if.o_lap); end
        n_chk++; if (sw_if.o_tick !== 1'b0) begin n_err++; $display("FAIL ar_tick: got %b expected 0", sw_if.o_tick); end
        n_chk++; if (sw_if.o_state !== 2'b00) begin n_err++; $display("FAIL ar_state: got %b expected 00", sw_if.o_state); end
        repeat (2) step();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_chk++;
            if (sw_if.o_state !== 2'b00 || sw_if.o_tick !== 1'b0) begin
                n_err++; $display("FAIL ar_idle_k%0d: got state=%b tick=%b expected 00/0", k, sw_if.o_state, sw_if.o_tick);
            end
        end
        pulse(1'b1, 1'b0, 1'b0);
        n_chk++; if (sw_if.o_state !== 2'b01) begin n_err++; $display("FAIL ar_rerun_state: got %b expected 01", sw_if.o_state); end
        for (int k = 1; k <= 10; k++) begin
            step();
            n_chk++;
            if (sw_if.o_tick !== (k == 10)) begin
                n_err++; $display("FAIL ar_cnt_tick_k%0d: got %b expected %b", k, sw_if.o_tick, (k == 10));
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        test_reset();
        test_run_tick();
        test_stop_resume();
        test_clear();
        test_lap();
        test_clear_in_run_stop_at_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
